// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: capture FSM state encodings and default baud divider
package uart_pkg;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  // clk cycles per bit minus 1; shared with uart_tx so both ends power up at the same rate
  localparam logic [15:0] UART_DEFAULT_DIVIDER = 16'd867;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop/flush; level is the full/empty authority
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push;

  // a push into a full FIFO is legal only when the head leaves on the same edge
  assign w_pop  = pop && (r_level != '0);
  assign w_push = push && ((r_level != FULL_LVL) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == FULL_LVL);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx bus-side controller: divider reg, byte capture handshake,
// receive FIFO, sticky overrun and idle timeout
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int          DEPTH           = 8,
  parameter logic [15:0] DEFAULT_DIVIDER = UART_DEFAULT_DIVIDER,
  parameter int          TIMEOUT_CYCLES  = 20000,
  localparam int         LW              = $clog2(DEPTH + 1)
) (
  input  logic          uart_clk,
  input  logic          uart_rst_n,
  input  logic          cfg_div_wr,
  input  logic [15:0]   cfg_div,
  output logic [15:0]   rx_divider,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic          rx_ready_rst,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  input  logic          rd_ready,
  output logic [LW-1:0] fifo_level,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic          idle_timeout
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);

  logic [0:0]    r_state;
  logic [15:0]   r_divider;
  logic          r_ready_rst;
  logic          r_overrun;
  logic          r_idle;
  logic [CW-1:0] r_idle_cnt;

  logic          w_capture;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic          w_cnt_clr;
  logic [LW-1:0] w_level;

  assign w_capture = (r_state == ST_WAIT) && rx_ready;
  assign w_pop     = rd_valid && rd_ready;
  assign w_drop    = w_capture && w_full && !w_pop;
  // a flush on the capture edge discards the byte as well
  assign w_push    = w_capture && !w_drop && !cfg_div_wr;
  assign w_cnt_clr = w_push || w_pop || cfg_div_wr;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (uart_clk),
    .rst_n (uart_rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (cfg_div_wr),
    .din   (rx_data),
    .dout  (rd_data),
    .level (w_level),
    .full  (w_full)
  );

  always_ff @(posedge uart_clk) begin
    if (!uart_rst_n) begin
      r_state     <= ST_WAIT;
      r_ready_rst <= 1'b0;
      r_divider   <= DEFAULT_DIVIDER;
      r_overrun   <= 1'b0;
    end else begin
      if (cfg_div_wr) r_divider <= cfg_div;
      if (w_drop)           r_overrun <= 1'b1;
      else if (overrun_clr) r_overrun <= 1'b0;
      case (r_state)
        ST_WAIT: if (rx_ready) begin
          r_ready_rst <= 1'b1;
          r_state     <= ST_ACK;
        end
        default: if (!rx_ready) begin
          r_ready_rst <= 1'b0;
          r_state     <= ST_WAIT;
        end
      endcase
    end
  end

  // counter parks at TIMEOUT_CYCLES so the pulse fires once per idle stretch
  always_ff @(posedge uart_clk) begin
    if (!uart_rst_n) begin
      r_idle_cnt <= '0;
      r_idle     <= 1'b0;
    end else begin
      r_idle <= !w_cnt_clr && (w_level != '0) && (r_idle_cnt == TO_LAST);
      if (w_cnt_clr || (w_level == '0)) r_idle_cnt <= '0;
      else if (r_idle_cnt != TO_MAX)    r_idle_cnt <= r_idle_cnt + CW'(1);
    end
  end

  assign rx_divider   = r_divider;
  assign rx_ready_rst = r_ready_rst;
  assign rd_valid     = (w_level != '0);
  assign fifo_level   = w_level;
  assign overrun      = r_overrun;
  assign idle_timeout = r_idle;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_div_wr;
  logic [15:0] cfg_div;
  logic [15:0] rx_divider;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_ready_rst;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic        overrun_clr;
  logic        idle_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(8), .DEFAULT_DIVIDER(16'd867), .TIMEOUT_CYCLES(50)) dut (
    .uart_clk     (clk),
    .uart_rst_n   (rst_n),
    .cfg_div_wr   (cfg_div_wr),
    .cfg_div      (cfg_div),
    .rx_divider   (rx_divider),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_ready_rst (rx_ready_rst),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .idle_timeout (idle_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy_rst"}, {31'd0, rx_ready_rst}, 32'd0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    chk({tag, "_level"}, {28'd0, fifo_level}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_idle"}, {31'd0, idle_timeout}, 32'd0);
    chk({tag, "_div"}, {16'd0, rx_divider}, 32'd867);
  endtask

  initial begin
    int pulses;
    int first_k;
    rst_n = 1'b0; cfg_div_wr = 1'b0; cfg_div = '0; rx_data = '0;
    rx_ready = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    step(); step();
    chk_reset_state("reset");
    rst_n = 1'b1;
    step();

    // single byte handshake
    rx_data = 8'hA5; rx_ready = 1'b1;
    step();
    chk("t1_rdy_rst_set", {31'd0, rx_ready_rst}, 32'd1);
    chk("t1_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("t1_rd_data", {24'd0, rd_data}, 32'hA5);
    chk("t1_level", {28'd0, fifo_level}, 32'd1);
    step();
    chk("t1_rdy_rst_hold", {31'd0, rx_ready_rst}, 32'd1);
    chk("t1_no_double_push", {28'd0, fifo_level}, 32'd1);
    rx_ready = 1'b0;
    step();
    chk("t1_rdy_rst_clr", {31'd0, rx_ready_rst}, 32'd0);
    chk("t1_div", {16'd0, rx_divider}, 32'd867);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("t1_drained", {28'd0, fifo_level}, 32'd0);

    // fill, overrun on 9th, drain in order
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    chk("t2_level_full", {28'd0, fifo_level}, 32'd8);
    send_byte(8'h09);
    chk("t2_overrun", {31'd0, overrun}, 32'd1);
    chk("t2_level_after_drop", {28'd0, fifo_level}, 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_drain_valid", {31'd0, rd_valid}, 32'd1);
      chk("t2_drain_data", {24'd0, rd_data}, 32'(i));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    chk("t2_empty", {31'd0, rd_valid}, 32'd0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t2_overrun_clr", {31'd0, overrun}, 32'd0);

    // full FIFO with pop on the capture edge
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    rx_data = 8'h09; rx_ready = 1'b1; rd_ready = 1'b1;
    step();
    rx_ready = 1'b0; rd_ready = 1'b0;
    chk("t3_level", {28'd0, fifo_level}, 32'd8);
    chk("t3_no_overrun", {31'd0, overrun}, 32'd0);
    chk("t3_head", {24'd0, rd_data}, 32'h02);
    step();
    for (int i = 2; i <= 9; i++) begin
      chk("t3_drain_data", {24'd0, rd_data}, 32'(i));
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    chk("t3_empty", {28'd0, fifo_level}, 32'd0);

    // divider write flushes the FIFO
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("t4_level3", {28'd0, fifo_level}, 32'd3);
    cfg_div = 16'd433; cfg_div_wr = 1'b1;
    step();
    cfg_div_wr = 1'b0;
    chk("t4_div", {16'd0, rx_divider}, 32'd433);
    chk("t4_level0", {28'd0, fifo_level}, 32'd0);
    chk("t4_rd_valid", {31'd0, rd_valid}, 32'd0);

    // idle timeout: none while empty, exactly one pulse 50 cycles after push
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (idle_timeout) pulses++;
    end
    chk("t5_no_pulse_empty", 32'(pulses), 32'd0);
    rx_data = 8'h5A; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    first_k = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (idle_timeout) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
    chk("t5_pulse_count", 32'(pulses), 32'd1);
    chk("t5_pulse_cycle", 32'(first_k), 32'd50);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

    // overrun set beats clear; reset mid-ACK
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h40 + i));
    rx_data = 8'h49; rx_ready = 1'b1; overrun_clr = 1'b1;
    step();
    rx_ready = 1'b0; overrun_clr = 1'b0;
    chk("t6_set_wins", {31'd0, overrun}, 32'd1);
    step();
    rx_data = 8'h4A; rx_ready = 1'b1;
    step();
    chk("t6_in_ack", {31'd0, rx_ready_rst}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_reset_state("t6_reset");
    rst_n = 1'b1; rx_data = 8'hC3;
    step();
    chk("t6_recapture_level", {28'd0, fifo_level}, 32'd1);
    chk("t6_recapture_data", {24'd0, rd_data}, 32'hC3);
    chk("t6_recapture_ack", {31'd0, rx_ready_rst}, 32'd1);
    rx_ready = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
